// File: rtl/uart_pkt_rx.sv
// Frames UART bytes (SYNC, LEN, LEN*4 payload, XOR CHK) into 32-bit words; bytes act one cycle after rx_valid.
// Words drain on valid/ready and hold while stalled; rx bytes cannot be stalled, so a byte during drain is dropped as overrun.
module uart_pkt_rx #(
  parameter int         MAX_WORDS    = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic        busy
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]    MAX_LEN  = 8'(MAX_WORDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t          state;
  logic [AW-1:0]   len_m1;
  logic [AW-1:0]   word_idx;
  logic [AW-1:0]   rd_ptr;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift_q;
  logic [7:0]      chk;
  logic [TW-1:0]   tmo_cnt;
  logic [31:0]     pkt_buf [MAX_WORDS];

  logic            wr_en;
  logic [31:0]     wr_dat;
  logic [AW-1:0]   rd_nxt;

  assign wr_en  = (state == S_PAYLOAD) && rx_valid && (byte_cnt == 2'd3);
  assign wr_dat = {rx_data, shift_q};
  assign rd_nxt = rd_ptr + AW'(1);

  // Buffer contents need no reset: they are only presented after a full, checked packet.
  always_ff @(posedge clk) begin
    if (wr_en) pkt_buf[word_idx] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_m1     <= '0;
      word_idx   <= '0;
      rd_ptr     <= '0;
      byte_cnt   <= '0;
      shift_q    <= '0;
      chk        <= '0;
      tmo_cnt    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      pkt_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state <= S_LEN;
            busy  <= 1'b1;
          end
        end
        S_LEN, S_PAYLOAD, S_CHK: begin
          // A byte arriving on the limit cycle takes priority over the timeout.
          if (rx_valid) begin
            tmo_cnt <= '0;
            if (state == S_LEN) begin
              if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
                pkt_err  <= 1'b1;
                err_code <= 3'd1;
                state    <= S_IDLE;
                busy     <= 1'b0;
              end else begin
                len_m1   <= AW'(rx_data - 8'd1);
                chk      <= rx_data;
                byte_cnt <= '0;
                word_idx <= '0;
                state    <= S_PAYLOAD;
              end
            end else if (state == S_PAYLOAD) begin
              chk      <= chk ^ rx_data;
              shift_q  <= {rx_data, shift_q[23:8]};
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                word_idx <= word_idx + AW'(1);
                if (word_idx == len_m1) state <= S_CHK;
              end
            end else if (rx_data == chk) begin
              pkt_ok     <= 1'b1;
              rd_ptr     <= '0;
              word_data  <= pkt_buf[0];
              word_last  <= (len_m1 == '0);
              word_valid <= 1'b1;
              state      <= S_DRAIN;
            end else begin
              pkt_err  <= 1'b1;
              err_code <= 3'd2;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            pkt_err  <= 1'b1;
            err_code <= 3'd3;
            tmo_cnt  <= '0;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_DRAIN: begin
          if (rx_valid) begin
            pkt_err  <= 1'b1;
            err_code <= 3'd4;
          end
          if (word_valid && word_ready) begin
            if (word_last) begin
              word_valid <= 1'b0;
              word_last  <= 1'b0;
              state      <= S_IDLE;
              busy       <= 1'b0;
            end else begin
              rd_ptr    <= rd_nxt;
              word_data <= pkt_buf[rd_nxt];
              word_last <= (rd_nxt == len_m1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Scoreboard bench for uart_pkt_rx: expected words and ok/error events are queued as frames are sent.
module tb_uart_pkt_rx;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic        pkt_ok;
  logic        pkt_err;
  logic [2:0]  err_code;
  logic        busy;

  uart_pkt_rx #(.MAX_WORDS(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_last(word_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  logic [32:0] exp_words [$];
  logic [2:0]  exp_evt [$];
  logic [31:0] tx_words [$];
  int          last_strobe = 0;
  int          gap = 2;

  // Monitor: handshakes, events, latency and hold-while-stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_last;
  always @(negedge clk) begin
    logic [32:0] ew;
    logic [2:0]  ee;
    logic [2:0]  code;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", word_valid, 1);
        check("hold_dat", word_data, prev_dat);
        check("hold_last", word_last, prev_last);
      end
      prev_stall = word_valid && !word_ready;
      prev_dat   = word_data;
      prev_last  = word_last;
      if (word_valid && word_ready) begin
        if (exp_words.size() == 0) check("word_unexpected", word_valid, 0);
        else begin
          ew = exp_words.pop_front();
          check("word", {word_last, word_data}, ew);
        end
      end
      if (pkt_ok || pkt_err) begin
        code = pkt_ok ? 3'd0 : err_code;
        check("ok_err_excl", pkt_ok & pkt_err, 0);
        if (exp_evt.size() == 0) check("evt_unexpected", {pkt_ok, pkt_err}, 0);
        else begin
          ee = exp_evt.pop_front();
          check("evt_code", code, ee);
          check("evt_lat", cyc - last_strobe, (ee == 3'd3) ? TMO + 1 : 1);
          if (ee == 3'd0) check("ok_word0_vld", word_valid, 1);
          if (ee inside {3'd1, 3'd2, 3'd3}) check("err_idle", busy, 0);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data     = b;
    rx_valid    = 1'b1;
    last_strobe = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Sends tx_words as one frame; bad corrupts the checksum byte.
  task automatic send_pkt(input bit bad);
    logic [7:0] c;
    int n;
    n = tx_words.size();
    c = 8'(n);
    exp_evt.push_back(bad ? 3'd2 : 3'd0);
    if (!bad)
      for (int i = 0; i < n; i++) exp_words.push_back({(i == n - 1), tx_words[i]});
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        c = c ^ tx_words[i][8*k +: 8];
        send_byte(tx_words[i][8*k +: 8]);
      end
    send_byte(bad ? (c ^ 8'h01) : c);
    tx_words.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_words.size() != 0 || exp_evt.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("idle_reached", (n < budget), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", word_valid, 0);
    check("rst_last", word_last, 0);
    check("rst_ok", pkt_ok, 0);
    check("rst_err", pkt_err, 0);
    check("rst_code", err_code, 0);
    check("rst_dat", word_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single word, slow pace
    gap = 50;
    tx_words.push_back(32'h12345678);
    send_pkt(0);
    wait_idle(1000);
    gap = 2;

    // Two words, downstream stalled for 5 cycles after pkt_ok
    gap = 0;
    word_ready = 1'b0;
    tx_words.push_back(32'h00000000);
    tx_words.push_back(32'hFFFFFFFF);
    send_pkt(0);
    repeat (5) @(posedge clk);
    #1 word_ready = 1'b1;
    wait_idle(1000);
    gap = 2;

    // Bad checksum, then a good packet
    tx_words.push_back(32'h12345678);
    send_pkt(1);
    wait_idle(1000);
    tx_words.push_back(32'hCAFEF00D);
    send_pkt(0);
    wait_idle(1000);

    // Bad LEN 0 and 17, then a good packet right behind
    exp_evt.push_back(3'd1);
    send_byte(8'hA5); send_byte(8'h00);
    exp_evt.push_back(3'd1);
    send_byte(8'hA5); send_byte(8'h11);
    tx_words.push_back(32'hA5A5A5A5);
    tx_words.push_back(32'h0102A503);
    tx_words.push_back(32'h11111111);
    send_pkt(0);
    wait_idle(1000);

    // Leading junk is silently dropped
    send_byte(8'h3C); send_byte(8'h00);
    tx_words.push_back(32'h89ABCDEF);
    send_pkt(0);
    wait_idle(1000);

    // Maximum length packet
    for (int i = 0; i < 16; i++) tx_words.push_back($urandom);
    send_pkt(0);
    wait_idle(1000);

    // Timeout after LEN
    exp_evt.push_back(3'd3);
    send_byte(8'hA5); send_byte(8'h02);
    wait_idle(1000);

    // Overrun during a stalled drain
    word_ready = 1'b0;
    tx_words.push_back(32'hDEADBEEF);
    send_pkt(0);
    exp_evt.push_back(3'd4);
    send_byte(8'h33);
    repeat (3) @(posedge clk);
    #1 word_ready = 1'b1;
    wait_idle(1000);

    // Reset mid-payload
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vld", word_valid, 0);
    check("mid_rst_err", pkt_err, 0);
    check("mid_rst_code", err_code, 0);
    rst = 1'b0;
    tx_words.push_back(32'h5A5A0FF0);
    send_pkt(0);
    wait_idle(1000);

    repeat (5) @(posedge clk);
    #1;
    check("evt_left", exp_evt.size(), 0);
    check("words_left", exp_words.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
